// File: rtl/id_ex_decode_if.sv
// Decode-stage bus: fetch handshake and flush in, registered EX controls out.
// Master is the surrounding pipeline, slave is id_ex_decode.
interface id_ex_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [3:0]      ex_alusel;
  logic            ex_a_sel;
  logic            ex_b_sel;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_regwen;
  logic            ex_memren;
  logic            ex_memwen;
  logic [1:0]      ex_wbsel;
  logic            ex_illegal;

  modport master (
    output id_valid, id_inst, id_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_alusel, ex_a_sel, ex_b_sel, ex_imm, ex_pc,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_regwen, ex_memren, ex_memwen,
           ex_wbsel, ex_illegal
  );

  modport slave (
    input  id_valid, id_inst, id_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_alusel, ex_a_sel, ex_b_sel, ex_imm, ex_pc,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_regwen, ex_memren, ex_memwen,
           ex_wbsel, ex_illegal
  );
endinterface

// File: rtl/id_ex_decode.sv
// RV32I decode + ID/EX register: one-cycle latency from id handshake to ex_* fields.
// id_ready falls only while a held entry is stalled by EX; flush drops both the load and the held entry.
module id_ex_decode #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
  input logic           clock,
  input logic           reset,
  id_ex_decode_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_OR   = 4'b0000, ALU_JAL  = 4'b0001, ALU_JALR = 4'b0010, ALU_BR   = 4'b0011,
    ALU_SUB  = 4'b0100, ALU_SLTU = 4'b0110, ALU_SRL  = 4'b0111, ALU_ADD  = 4'b1000,
    ALU_LUI  = 4'b1001, ALU_XOR  = 4'b1010, ALU_SRA  = 4'b1011, ALU_SLT  = 4'b1100,
    ALU_SLL  = 4'b1110, ALU_AND  = 4'b1111
  } alusel_e;

  typedef struct packed {
    logic [3:0]      alusel;
    logic            a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            regwen;
    logic            memren;
    logic            memwen;
    logic [1:0]      wbsel;
    logic            illegal;
  } ex_t;

  localparam ex_t EX_RST = '{pc: RESET_PC, default: '0};

  function automatic logic [XLEN-1:0] xl(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Operation selected by funct3 when funct7 is the base encoding.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign inst   = bus.id_inst;
  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  ex_t  ex_d;
  ex_t  ex_q;
  logic bad;
  logic vld_d;
  logic vld_q;
  logic load;

  always_comb begin
    ex_d        = '0;
    bad         = 1'b0;
    ex_d.pc     = bus.id_pc;
    ex_d.funct3 = f3;
    ex_d.alusel = ALU_ADD;
    case (opc)
      OPC_LUI: begin
        ex_d.alusel = ALU_LUI;
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_u);
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
      end
      OPC_AUIPC: begin
        ex_d.a_sel  = 1'b1;
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_u);
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
      end
      OPC_JAL: begin
        ex_d.alusel = ALU_JAL;
        ex_d.a_sel  = 1'b1;
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_j);
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
        ex_d.wbsel  = 2'b10;
      end
      OPC_JALR: begin
        bad         = (f3 != 3'b000);
        ex_d.alusel = ALU_JALR;
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_i);
        ex_d.rs1    = rs1;
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
        ex_d.wbsel  = 2'b10;
      end
      OPC_BRANCH: begin
        bad         = (f3[2:1] == 2'b01);
        ex_d.alusel = ALU_BR;
        ex_d.a_sel  = 1'b1;
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_b);
        ex_d.rs1    = rs1;
        ex_d.rs2    = rs2;
      end
      OPC_LOAD: begin
        bad         = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_i);
        ex_d.rs1    = rs1;
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
        ex_d.memren = 1'b1;
        ex_d.wbsel  = 2'b01;
      end
      OPC_STORE: begin
        bad         = f3[2] || (f3[1:0] == 2'b11);
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_s);
        ex_d.rs1    = rs1;
        ex_d.rs2    = rs2;
        ex_d.memwen = 1'b1;
      end
      OPC_OPIMM: begin
        ex_d.alusel = base_alu(f3);
        ex_d.b_sel  = 1'b1;
        ex_d.imm    = xl(imm_i);
        ex_d.rs1    = rs1;
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
        // Shift-immediates reuse the funct7 slot, so it must be validated here.
        if (f3 == 3'b001) begin
          ex_d.imm = xl(imm_sh);
          bad      = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          ex_d.imm = xl(imm_sh);
          if (f7 == F7_ALT) ex_d.alusel = ALU_SRA;
          else              bad         = (f7 != F7_BASE);
        end
      end
      OPC_OP: begin
        ex_d.alusel = base_alu(f3);
        ex_d.rs1    = rs1;
        ex_d.rs2    = rs2;
        ex_d.rd     = rd;
        ex_d.regwen = 1'b1;
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      ex_d.alusel = ALU_SUB;
          else if (f3 == 3'b101) ex_d.alusel = ALU_SRA;
          else                   bad         = 1'b1;
        end else if (f7 != F7_BASE) begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ex_d         = '0;
      ex_d.pc      = bus.id_pc;
      ex_d.funct3  = f3;
      ex_d.alusel  = ALU_ADD;
      ex_d.illegal = 1'b1;
    end
    if (ex_d.rd == 5'd0) ex_d.regwen = 1'b0;
  end

  assign bus.id_ready = !vld_q || bus.ex_ready;
  assign load         = bus.id_valid && bus.id_ready && !bus.flush;
  assign vld_d        = !bus.flush && (load || (vld_q && !bus.ex_ready));

  // Data fields only move on a load, so stall and drain both leave them untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      ex_q  <= EX_RST;
    end else begin
      vld_q <= vld_d;
      if (load) ex_q <= ex_d;
    end
  end

  assign bus.ex_valid   = vld_q;
  assign bus.ex_alusel  = ex_q.alusel;
  assign bus.ex_a_sel   = ex_q.a_sel;
  assign bus.ex_b_sel   = ex_q.b_sel;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_rs1     = ex_q.rs1;
  assign bus.ex_rs2     = ex_q.rs2;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_funct3  = ex_q.funct3;
  assign bus.ex_regwen  = ex_q.regwen;
  assign bus.ex_memren  = ex_q.memren;
  assign bus.ex_memwen  = ex_q.memwen;
  assign bus.ex_wbsel   = ex_q.wbsel;
  assign bus.ex_illegal = ex_q.illegal;
endmodule
